// File: rtl/fifo_protocol_checker_if.sv
// Purpose: bundle of the monitored FIFO's request, data and status signals.
// Ports: wr_en/rd_en strobes, data_in/data_out buses, and the full, empty,
//        almostfull, almostempty, wr_ack, overflow and underflow status outputs.
// master = the FIFO side (drives everything); slave = the checker (observes only).
interface fifo_protocol_checker_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, rd_en, data_in, data_out,
        output full, empty, almostfull, almostempty, wr_ack, overflow, underflow
    );

    modport slave (
        input wr_en, rd_en, data_in, data_out,
        input full, empty, almostfull, almostempty, wr_ack, overflow, underflow
    );
endinterface

// File: rtl/fifo_protocol_checker.sv
// Purpose: passive protocol checker that shadows a FIFO and flags status/data mismatches.
// Latency: err_vec is registered one edge after the sampled cycle; status outputs update at that same edge.
// Backpressure: none; the checker only observes and never stalls the FIFO.
//
// Ports: clk, rst_n (synchronous, active low); mon (slave view of the FIFO);
//        clr_err clears err_flag/first_err; err_vec, first_err, err_flag,
//        err_count, chk_count, shadow_count report the checking result.
// Build option: define DATA_CHECK_EN to add a shadow data buffer and check
//        data_out (err_vec bit7); without it, bit7 is constant 0.
module fifo_protocol_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fifo_protocol_checker_if.slave       mon,
    input  logic                         clr_err,
    output logic [7:0]                   err_vec,
    output logic [7:0]                   first_err,
    output logic                         err_flag,
    output logic [CNT_WIDTH-1:0]         err_count,
    output logic [CNT_WIDTH-1:0]         chk_count,
    output logic [$clog2(DEPTH+1)-1:0]   shadow_count
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 exp_wr_ack_q, exp_ovf_q, exp_udf_q;
    logic [7:0]           err_vec_q, err_vec_d;
    logic [7:0]           first_err_q, first_err_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0] chk_count_q, chk_count_d;

    logic       wr_acc, rd_acc, checking;
    logic [7:0] mism;
    logic       data_mism;

    assign wr_acc   = mon.wr_en && (cnt_q != CNT_FULL);
    assign rd_acc   = mon.rd_en && (cnt_q != '0);
    assign checking = (state_q != ST_IDLE);

`ifdef DATA_CHECK_EN
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] shbuf_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] exp_dat_q;
    logic                  exp_dat_vld_q;

    // Storage itself is not reset; only the pointers and the pending expectation are.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            shbuf_q[wr_ptr_q] <= mon.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            exp_dat_q     <= '0;
            exp_dat_vld_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q  <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
                exp_dat_q <= shbuf_q[rd_ptr_q];
            end
            exp_dat_vld_q <= rd_acc;
        end
    end

    assign data_mism = exp_dat_vld_q && (mon.data_out != exp_dat_q);
`else
    logic unused_data;
    assign unused_data = ^{mon.data_in, mon.data_out};
    assign data_mism   = 1'b0;
`endif

    // Flags are compared against the occupancy before this edge's update.
    always_comb begin
        mism    = '0;
        mism[0] = mon.full        != (cnt_q == CNT_FULL);
        mism[1] = mon.empty       != (cnt_q == '0);
        mism[2] = mon.almostfull  != (cnt_q == CNT_AFULL);
        mism[3] = mon.almostempty != (cnt_q == CNT_ONE);
        mism[4] = mon.wr_ack      != exp_wr_ack_q;
        mism[5] = mon.overflow    != exp_ovf_q;
        mism[6] = mon.underflow   != exp_udf_q;
        mism[7] = data_mism;
    end

    always_comb begin
        err_vec_d   = checking ? mism : 8'h00;
        cnt_d       = cnt_q;
        state_d     = state_q;
        first_err_d = first_err_q;
        err_count_d = err_count_q;
        chk_count_d = chk_count_q;

        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (err_vec_d != 8'h00) begin
                    state_d     = ST_FAULT;
                    first_err_d = err_vec_d;
                end
            end
            ST_FAULT: begin
                // A fresh mismatch on the clearing edge re-arms the fault with the new vector.
                if (clr_err) begin
                    if (err_vec_d != 8'h00) begin
                        first_err_d = err_vec_d;
                    end else begin
                        state_d     = ST_RUN;
                        first_err_d = 8'h00;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (checking && (chk_count_q != '1)) begin
            chk_count_d = chk_count_q + CNT_WIDTH'(1);
        end
        if ((err_vec_d != 8'h00) && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            exp_wr_ack_q <= 1'b0;
            exp_ovf_q    <= 1'b0;
            exp_udf_q    <= 1'b0;
            err_vec_q    <= '0;
            first_err_q  <= '0;
            err_count_q  <= '0;
            chk_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_wr_ack_q <= wr_acc;
            exp_ovf_q    <= mon.wr_en && (cnt_q == CNT_FULL);
            // A write landing on an empty FIFO in the same cycle masks the underflow.
            exp_udf_q    <= mon.rd_en && !mon.wr_en && (cnt_q == '0);
            err_vec_q    <= err_vec_d;
            first_err_q  <= first_err_d;
            err_count_q  <= err_count_d;
            chk_count_q  <= chk_count_d;
        end
    end

    assign err_vec      = err_vec_q;
    assign first_err    = first_err_q;
    assign err_flag     = (state_q == ST_FAULT);
    assign err_count    = err_count_q;
    assign chk_count    = chk_count_q;
    assign shadow_count = cnt_q;
endmodule
